// File: rtl/mc_control_sequencer.sv
// mc_control_sequencer: multicycle control sequencer for the single-issue datapath.
//
// Decodes opcode/func once per instruction (on entry to DECODE) into a latched control word.
// It then walks RESET/FETCH/DECODE/SETTLE/MEM/WB/DONE/HALT and pulses the strobes.
// Every output is registered and reflects the state the sequencer is currently in.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-low reset
//   opcode, func    - instruction fields (opcode stable FETCH..DONE)
//   INT             - interrupt/resume request, sampled only in HALT
//   memRdy          - memory completion, sampled only in MEM
//   aluOp, brOp     - ALU / branch operation selects (zero-extended to parameter width)
//   aluSrc, regAluOut, immSel, isCmov, isCall - datapath selects from the control word
//   rdMem, wrMem    - memory strobes, held through MEM
//   wrReg, mToReg   - register write (and load-data select) for the single WB cycle
//   updPC           - PC update for the single DONE cycle
//   illegal         - one-cycle pulse in DECODE for an undefined opcode
//   busErr          - sticky memory-timeout flag, cleared only by reset
//   halted          - high while in HALT
module mc_control_sequencer #(
  parameter int unsigned ALU_OP_W    = 4,
  parameter int unsigned BR_OP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [4:0]          func,
  input  logic                INT,
  input  logic                memRdy,
  output logic [ALU_OP_W-1:0] aluOp,
  output logic [BR_OP_W-1:0]  brOp,
  output logic                aluSrc,
  output logic                regAluOut,
  output logic                immSel,
  output logic                isCmov,
  output logic                rdMem,
  output logic                wrMem,
  output logic                wrReg,
  output logic                mToReg,
  output logic                updPC,
  output logic                isCall,
  output logic                illegal,
  output logic                busErr,
  output logic                halted
);

  // Counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StReset, StFetch, StDecode, StSettle, StMem, StWb, StDone, StHalt
  } state_e;

  // Path class chosen in DECODE; steers the rest of the instruction.
  typedef enum logic [2:0] {
    ClsAlu, ClsSettleWb, ClsLd, ClsSt, ClsBr, ClsNop, ClsHalt
  } cls_e;

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [BR_OP_W-1:0]  br_op_q, br_op_d;
  logic                alu_src_q, alu_src_d;
  logic                reg_alu_out_q, reg_alu_out_d;
  logic                imm_sel_q, imm_sel_d;
  logic                is_cmov_q, is_cmov_d;
  logic                is_call_q, is_call_d;
  logic                rd_mem_q, rd_mem_d;
  logic                wr_mem_q, wr_mem_d;
  logic                wr_reg_q, wr_reg_d;
  logic                m_to_reg_q, m_to_reg_d;
  logic                upd_pc_q, upd_pc_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                halted_q, halted_d;

  // Decoded control word for the current opcode (only captured on FETCH -> DECODE).
  logic [3:0] dec_alu;
  logic [2:0] dec_br;
  logic       dec_alu_src, dec_reg_alu_out, dec_imm_sel, dec_cmov, dec_call, dec_illegal;
  cls_e       dec_cls;

  // func[4] is not part of any encoding.
  logic unused_func;
  assign unused_func = func[4];

  always_comb begin
    dec_alu         = 4'h0;
    dec_br          = 3'b100;
    dec_alu_src     = 1'b0;
    dec_reg_alu_out = 1'b0;
    dec_imm_sel     = 1'b0;
    dec_cmov        = 1'b0;
    dec_call        = 1'b0;
    dec_illegal     = 1'b0;
    dec_cls         = ClsNop;
    if (opcode == 6'h00) begin
      dec_alu         = func[3:0] - 4'd1;
      dec_alu_src     = 1'b1;
      dec_reg_alu_out = 1'b1;
      dec_cls         = ClsAlu;
    end else if (opcode <= 6'h0F) begin
      dec_alu = opcode[3:0] - 4'd1;
      dec_cls = ClsAlu;
    end else begin
      case (opcode)
        6'h10: begin
          dec_alu = 4'hF;
          dec_cls = ClsAlu;
        end
        6'h11: dec_cls = ClsLd;
        6'h12: dec_cls = ClsSt;
        6'h14: begin
          dec_alu_src     = 1'b1;
          dec_reg_alu_out = 1'b1;
          dec_cls         = ClsAlu;
        end
        6'h15: begin
          dec_alu_src     = 1'b1;
          dec_reg_alu_out = 1'b1;
          dec_cmov        = 1'b1;
          dec_cls         = ClsSettleWb;
        end
        6'h20, 6'h21, 6'h22, 6'h23: begin
          dec_br      = {1'b0, opcode[1:0]};
          dec_imm_sel = 1'b1;
          dec_cls     = ClsBr;
        end
        6'h24: dec_cls = ClsHalt;
        6'h25: dec_cls = ClsNop;
        6'h26: begin
          dec_br      = 3'b000;
          dec_imm_sel = 1'b1;
          dec_call    = 1'b1;
          dec_cls     = ClsSettleWb;
        end
        default: begin
          dec_illegal = 1'b1;
          dec_cls     = ClsNop;
        end
      endcase
    end
  end

  // Next state plus next registered outputs; outputs are derived from the state being entered.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    cnt_d         = '0;
    alu_op_d      = alu_op_q;
    br_op_d       = br_op_q;
    alu_src_d     = alu_src_q;
    reg_alu_out_d = reg_alu_out_q;
    imm_sel_d     = imm_sel_q;
    is_cmov_d     = is_cmov_q;
    is_call_d     = is_call_q;
    illegal_d     = 1'b0;
    bus_err_d     = bus_err_q;

    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        state_d       = StDecode;
        cls_d         = dec_cls;
        alu_op_d      = ALU_OP_W'(dec_alu);
        br_op_d       = BR_OP_W'(dec_br);
        alu_src_d     = dec_alu_src;
        reg_alu_out_d = dec_reg_alu_out;
        imm_sel_d     = dec_imm_sel;
        is_cmov_d     = dec_cmov;
        is_call_d     = dec_call;
        illegal_d     = dec_illegal;
      end
      StDecode: begin
        unique case (cls_q)
          ClsAlu:      state_d = StWb;
          ClsSettleWb: state_d = StSettle;
          ClsLd:       state_d = StMem;
          ClsSt:       state_d = StSettle;
          ClsBr:       state_d = StSettle;
          ClsHalt:     state_d = StHalt;
          default:     state_d = StDone;
        endcase
      end
      StSettle: begin
        unique case (cls_q)
          ClsSettleWb: state_d = StWb;
          ClsSt:       state_d = StMem;
          default:     state_d = StDone;
        endcase
      end
      StMem: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (memRdy) begin
          state_d = (cls_q == ClsLd) ? StWb : StDone;
        end else if (cnt_q == CntLast) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb:    state_d = StDone;
      StDone:  state_d = StFetch;
      StHalt:  if (INT) state_d = StDone;
      default: state_d = StReset;
    endcase

    rd_mem_d   = (state_d == StMem) && (cls_d == ClsLd);
    wr_mem_d   = (state_d == StMem) && (cls_d == ClsSt);
    wr_reg_d   = (state_d == StWb);
    m_to_reg_d = (state_d == StWb) && (cls_d == ClsLd);
    upd_pc_d   = (state_d == StDone);
    halted_d   = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StReset;
      cls_q         <= ClsNop;
      cnt_q         <= '0;
      alu_op_q      <= '0;
      br_op_q       <= BR_OP_W'(3'b100);
      alu_src_q     <= 1'b0;
      reg_alu_out_q <= 1'b0;
      imm_sel_q     <= 1'b0;
      is_cmov_q     <= 1'b0;
      is_call_q     <= 1'b0;
      rd_mem_q      <= 1'b0;
      wr_mem_q      <= 1'b0;
      wr_reg_q      <= 1'b0;
      m_to_reg_q    <= 1'b0;
      upd_pc_q      <= 1'b0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      cnt_q         <= cnt_d;
      alu_op_q      <= alu_op_d;
      br_op_q       <= br_op_d;
      alu_src_q     <= alu_src_d;
      reg_alu_out_q <= reg_alu_out_d;
      imm_sel_q     <= imm_sel_d;
      is_cmov_q     <= is_cmov_d;
      is_call_q     <= is_call_d;
      rd_mem_q      <= rd_mem_d;
      wr_mem_q      <= wr_mem_d;
      wr_reg_q      <= wr_reg_d;
      m_to_reg_q    <= m_to_reg_d;
      upd_pc_q      <= upd_pc_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      halted_q      <= halted_d;
    end
  end

  assign aluOp     = alu_op_q;
  assign brOp      = br_op_q;
  assign aluSrc    = alu_src_q;
  assign regAluOut = reg_alu_out_q;
  assign immSel    = imm_sel_q;
  assign isCmov    = is_cmov_q;
  assign isCall    = is_call_q;
  assign rdMem     = rd_mem_q;
  assign wrMem     = wr_mem_q;
  assign wrReg     = wr_reg_q;
  assign mToReg    = m_to_reg_q;
  assign updPC     = upd_pc_q;
  assign illegal   = illegal_q;
  assign busErr    = bus_err_q;
  assign halted    = halted_q;

endmodule
